// File: rtl/mips_mmio_uart_tx.sv
// Memory-mapped UART transmitter: CPU stores to TXDATA are queued in a FIFO and sent 8N1, LSB first.
// Build option: define UART_TX_PARITY_EN for 8E1 frames (even-parity bit between data and stop).
`timescale 1ns/1ps
module mips_mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_8000,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        mips_cpu_clk,
    input  logic        mips_cpu_reset,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        uart_txd,
    output logic        tx_irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wp, rp, wp_next, rp_next;
    logic          empty, full, push, pop;
    logic          sel_tx, sel_st, busy, ovf;
    logic [BW-1:0] baud_cnt;
    logic          baud_done, last_bit;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          txd_d, irq_d;
    logic          unused_wdata;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    assign unused_wdata = ^Write_data[31:8];

    assign sel_tx    = MemWrite && (Address == BASE_ADDR);
    assign sel_st    = (Address == BASE_ADDR + 32'd4);
    assign empty     = (wp == rp);
    assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign push      = sel_tx && !full;
    assign pop       = (state == S_IDLE) && !empty;
    assign wp_next   = wp + {{AW{1'b0}}, push};
    assign rp_next   = rp + {{AW{1'b0}}, pop};
    assign busy      = (state != S_IDLE);
    assign baud_done = (baud_cnt == BAUD_MAX);
    assign last_bit  = (bit_cnt == 3'd7);
    assign Read_data = (MemRead && sel_st) ? {28'b0, ovf, busy, full, empty} : '0;

    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset) begin
            state    <= S_IDLE;
            uart_txd <= 1'b1;
            tx_irq   <= 1'b1;
        end else begin
            state    <= state_next;
            uart_txd <= txd_d;
            tx_irq   <= irq_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (!empty) state_next = S_START;
            S_START:  if (baud_done) state_next = S_DATA;
`ifdef UART_TX_PARITY_EN
            S_DATA:   if (baud_done && last_bit) state_next = S_PARITY;
`else
            S_DATA:   if (baud_done && last_bit) state_next = S_STOP;
`endif
            S_PARITY: if (baud_done) state_next = S_STOP;
            S_STOP:   if (baud_done) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Line and irq are registered from the next-cycle view so they change on the same edge as the FSM.
    always_comb begin
        txd_d = 1'b1;
        case (state_next)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = (state == S_DATA && baud_done) ? shift_reg[1] : shift_reg[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_bit;
`endif
            default:  txd_d = 1'b1;
        endcase
        irq_d = (state_next == S_IDLE) && (wp_next == rp_next);
    end

    always_ff @(posedge mips_cpu_clk) begin
        if (push) mem[wp[AW-1:0]] <= Write_data[7:0];
    end

    always_ff @(posedge mips_cpu_clk) begin
        if (mips_cpu_reset) begin
            wp        <= '0;
            rp        <= '0;
            ovf       <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            wp <= wp_next;
            rp <= rp_next;
            // An overflow in the same cycle as a clear keeps ovf set.
            if (sel_tx && full)
                ovf <= 1'b1;
            else if (MemWrite && sel_st && Write_data[3])
                ovf <= 1'b0;
            if (state == S_IDLE || baud_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + BW'(1);
            if (pop) begin
                shift_reg <= mem[rp[AW-1:0]];
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^mem[rp[AW-1:0]];
`endif
            end else if (state == S_DATA && baud_done) begin
                shift_reg <= shift_reg >> 1;
            end
            if (state != S_DATA)
                bit_cnt <= '0;
            else if (baud_done)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end
endmodule

// File: tb/tb_mips_mmio_uart_tx.sv
// Bench for mips_mmio_uart_tx: directed stores with a byte scoreboard and a serial-line frame decoder.
`timescale 1ns/1ps
module tb_mips_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h0000_8000;
    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FRAME = NB * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        uart_txd;
    logic        tx_irq;

    typedef struct {
        logic [7:0]  data;
        logic        ok;
        logic        par;
        int unsigned start;
    } frame_t;

    frame_t      rxq[$];
    logic [7:0]  expq[$];
    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    mips_mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .FIFO_DEPTH(DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .mips_cpu_clk(clk),
        .mips_cpu_reset(rst),
        .Address(Address),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .Write_data(Write_data),
        .Read_data(Read_data),
        .uart_txd(uart_txd),
        .tx_irq(tx_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        Address    = addr;
        Write_data = data;
        MemWrite   = 1'b1;
        tick();
        MemWrite   = 1'b0;
        Address    = '0;
        Write_data = '0;
    endtask

    task automatic read_reg(input logic [31:0] addr, output logic [31:0] v);
        Address = addr;
        MemRead = 1'b1;
        #1;
        v       = Read_data;
        MemRead = 1'b0;
        Address = '0;
    endtask

    task automatic expect_frame(input string tag, output int unsigned start);
        frame_t      f;
        logic [7:0]  e;
        int unsigned n = 0;
        while (rxq.size() == 0 && n < 3 * FRAME) begin
            tick();
            n++;
        end
        check({tag, " arrived"}, 32'(rxq.size() != 0), 32'd1);
        start = 0;
        if (rxq.size() != 0) begin
            f = rxq.pop_front();
            e = (expq.size() != 0) ? expq.pop_front() : 8'hxx;
            check({tag, " data"}, {24'b0, f.data}, {24'b0, e});
            check({tag, " framing"}, 32'(f.ok), 32'd1);
`ifdef UART_TX_PARITY_EN
            check({tag, " parity"}, 32'(f.par), 32'(^e));
`endif
            start = f.start;
        end
    endtask

    // Serial-line decoder: samples every cycle of each bit period, abandons a frame on reset.
    initial begin : rx_monitor
        frame_t      f;
        logic [10:0] bits;
        logic        good;
        logic        aborted;
        int unsigned s;
        forever begin
            @(posedge clk);
            #2;
            if (rst === 1'b0 && uart_txd === 1'b0) begin
                s       = cyc;
                good    = 1'b1;
                aborted = 1'b0;
                bits    = '1;
                for (int unsigned i = 0; i < NB * CPB; i++) begin
                    if (i != 0) begin
                        @(posedge clk);
                        #2;
                    end
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % CPB == 0)
                        bits[i / CPB] = uart_txd;
                    else if (uart_txd !== bits[i / CPB])
                        good = 1'b0;
                end
                if (!aborted) begin
                    f.data  = bits[8:1];
                    f.par   = bits[9];
                    f.start = s;
                    f.ok    = good && (bits[0] === 1'b0) && (bits[NB-1] === 1'b1);
                    rxq.push_back(f);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] v;
        int unsigned t0;
        int unsigned s;
        int unsigned prev;
        prev       = 0;
        rst        = 1'b1;
        Address    = '0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        Write_data = '0;

        repeat (3) tick();
        rst = 1'b0;
        read_reg(BASE + 32'd4, v);
        check("reset status", v, 32'h1);
        check("reset txd", 32'(uart_txd), 32'd1);
        check("reset irq", 32'(tx_irq), 32'd1);

        store(BASE, 32'h0000_AB55);
        expq.push_back(8'h55);
        t0 = cyc;
        check("irq after store", 32'(tx_irq), 32'd0);
        read_reg(BASE + 32'd4, v);
        check("status queued", v, 32'h0);
        tick();
        read_reg(BASE + 32'd4, v);
        check("status popped", v, 32'h5);
        repeat (FRAME - 1) tick();
        check("irq last stop cycle", 32'(tx_irq), 32'd0);
        tick();
        check("irq frame done", 32'(tx_irq), 32'd1);
        expect_frame("f55", s);
        check("f55 start latency", s, t0 + 1);

        tick();
        for (int unsigned i = 0; i < 6; i++) begin
            store(BASE, {24'hFFFF_FF, 8'hA1 + 8'(i)});
            if (i == 0) t0 = cyc;
            if (i < 5) expq.push_back(8'hA1 + 8'(i));
        end
        read_reg(BASE + 32'd4, v);
        check("burst status", v, 32'hE);
        check("burst irq", 32'(tx_irq), 32'd0);
        for (int unsigned i = 0; i < 5; i++) begin
            expect_frame("burst", s);
            if (i == 0)
                check("burst first start", s, t0 + 1);
            else
                check("burst gap", s - prev, FRAME + 1);
            prev = s;
        end
        tick();
        tick();
        read_reg(BASE + 32'd4, v);
        check("burst drained status", v, 32'h9);
        check("burst drained irq", 32'(tx_irq), 32'd1);

        store(BASE + 32'd4, 32'h0000_0008);
        read_reg(BASE + 32'd4, v);
        check("ovf cleared", v, 32'h1);

        for (int unsigned i = 0; i < 6; i++) begin
            store(BASE, {24'h0, 8'hB1 + 8'(i)});
            if (i < 5) expq.push_back(8'hB1 + 8'(i));
        end
        store(BASE + 32'd4, 32'hFFFF_FFF7);
        read_reg(BASE + 32'd4, v);
        check("ovf sticky", v, 32'hE);

        repeat (6) tick();
        rst = 1'b1;
        tick();
        check("mid reset txd", 32'(uart_txd), 32'd1);
        check("mid reset irq", 32'(tx_irq), 32'd1);
        read_reg(BASE + 32'd4, v);
        check("mid reset status", v, 32'h1);
        tick();
        rst = 1'b0;
        expq.delete();
        repeat (3 * FRAME) tick();
        check("no frame after reset", 32'(rxq.size()), 32'd0);
        check("idle line after reset", 32'(uart_txd), 32'd1);

        store(BASE + 32'd1, 32'h0000_0077);
        read_reg(BASE + 32'd4, v);
        check("misaligned store status", v, 32'h1);
        store(BASE + 32'd8, 32'h0000_0077);
        read_reg(BASE + 32'd4, v);
        check("out of range store status", v, 32'h1);
        check("decode irq", 32'(tx_irq), 32'd1);
        read_reg(BASE + 32'd5, v);
        check("misaligned status read", v, 32'h0);
        read_reg(BASE, v);
        check("txdata read", v, 32'h0);
        Address = BASE + 32'd4;
        #1;
        check("status without MemRead", Read_data, 32'h0);
        Address = '0;
        repeat (3 * FRAME) tick();
        check("no frame from bad address", 32'(rxq.size()), 32'd0);

        store(BASE, 32'h0000_0007);
        expq.push_back(8'h07);
        t0 = cyc;
        repeat (FRAME) tick();
        check("f07 irq last cycle", 32'(tx_irq), 32'd0);
        tick();
        check("f07 irq done", 32'(tx_irq), 32'd1);
        expect_frame("f07", s);
        check("f07 start latency", s, t0 + 1);

        check("scoreboard drained", 32'(expq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
